// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB snoop and issue signals between the scheduler and the ALU
// reservation station.
interface alu_reservation_station_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 3,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic              disp_valid;
  logic              disp_ready;
  logic [3:0]        disp_alu_op;
  logic [DATA_W-1:0] disp_src1_val;
  logic              disp_src1_rdy;
  logic [TAG_W-1:0]  disp_src1_tag;
  logic [DATA_W-1:0] disp_src2_val;
  logic              disp_src2_rdy;
  logic [TAG_W-1:0]  disp_src2_tag;
  logic [TAG_W-1:0]  disp_dst_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic              issue_valid;
  logic              issue_ready;
  logic [DATA_W-1:0] issue_op1;
  logic [DATA_W-1:0] issue_op2;
  logic [3:0]        issue_alu_op;
  logic [TAG_W-1:0]  issue_dst_tag;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output disp_valid, disp_alu_op, disp_src1_val, disp_src1_rdy, disp_src1_tag,
           disp_src2_val, disp_src2_rdy, disp_src2_tag, disp_dst_tag,
           cdb_valid, cdb_tag, cdb_value, issue_ready,
    input  disp_ready, issue_valid, issue_op1, issue_op2, issue_alu_op,
           issue_dst_tag, occupancy
  );

  modport slave (
    input  disp_valid, disp_alu_op, disp_src1_val, disp_src1_rdy, disp_src1_tag,
           disp_src2_val, disp_src2_rdy, disp_src2_tag, disp_dst_tag,
           cdb_valid, cdb_tag, cdb_value, issue_ready,
    output disp_ready, issue_valid, issue_op1, issue_op2, issue_alu_op,
           issue_dst_tag, occupancy
  );
endinterface

// File: rtl/alu_reservation_station.sv
// Age-ordered collapsing reservation station feeding the 16-bit ALU through a
// registered issue stage; pending operands are captured by snooping the CDB.
module alu_reservation_station #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 3,
  parameter int unsigned DATA_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  alu_reservation_station_if.slave bus
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [3:0]        alu_op;
    logic [TAG_W-1:0]  dst_tag;
    logic              rdy1;
    logic [TAG_W-1:0]  tag1;
    logic [DATA_W-1:0] val1;
    logic              rdy2;
    logic [TAG_W-1:0]  tag2;
    logic [DATA_W-1:0] val2;
  } entry_t;

  entry_t            ent     [DEPTH];
  entry_t            snooped [DEPTH];
  entry_t            ent_nxt [DEPTH];
  entry_t            sel_ent;
  entry_t            new_ent;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  occ_after;
  logic              found;
  int unsigned       sel;
  logic              accept;
  logic              load;

  logic              issue_valid;
  logic [DATA_W-1:0] issue_op1;
  logic [DATA_W-1:0] issue_op2;
  logic [3:0]        issue_alu_op;
  logic [TAG_W-1:0]  issue_dst_tag;

  assign bus.disp_ready    = (occ < FULL);
  assign bus.occupancy     = occ;
  assign bus.issue_valid   = issue_valid;
  assign bus.issue_op1     = issue_op1;
  assign bus.issue_op2     = issue_op2;
  assign bus.issue_alu_op  = issue_alu_op;
  assign bus.issue_dst_tag = issue_dst_tag;

  assign accept    = bus.disp_valid && bus.disp_ready;
  assign load      = (!issue_valid || bus.issue_ready) && found;
  assign occ_after = occ - OCC_W'(load);

  // Oldest eligible entry, judged on registered ready bits only.
  always_comb begin
    found   = 1'b0;
    sel     = 0;
    sel_ent = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!found && ent[i].valid && ent[i].rdy1 && ent[i].rdy2) begin
        found   = 1'b1;
        sel     = i;
        sel_ent = ent[i];
      end
    end
  end

  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.alu_op  = bus.disp_alu_op;
    new_ent.dst_tag = bus.disp_dst_tag;
    new_ent.tag1    = bus.disp_src1_tag;
    new_ent.tag2    = bus.disp_src2_tag;
    new_ent.rdy1    = bus.disp_src1_rdy;
    new_ent.val1    = bus.disp_src1_val;
    new_ent.rdy2    = bus.disp_src2_rdy;
    new_ent.val2    = bus.disp_src2_val;
    if (!bus.disp_src1_rdy && bus.cdb_valid && bus.cdb_tag == bus.disp_src1_tag) begin
      new_ent.rdy1 = 1'b1;
      new_ent.val1 = bus.cdb_value;
    end
    if (!bus.disp_src2_rdy && bus.cdb_valid && bus.cdb_tag == bus.disp_src2_tag) begin
      new_ent.rdy2 = 1'b1;
      new_ent.val2 = bus.cdb_value;
    end
  end

  // Snoop first, then collapse over the issued slot, then append the dispatch.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      snooped[i] = ent[i];
      if (ent[i].valid && bus.cdb_valid) begin
        if (!ent[i].rdy1 && ent[i].tag1 == bus.cdb_tag) begin
          snooped[i].rdy1 = 1'b1;
          snooped[i].val1 = bus.cdb_value;
        end
        if (!ent[i].rdy2 && ent[i].tag2 == bus.cdb_tag) begin
          snooped[i].rdy2 = 1'b1;
          snooped[i].val2 = bus.cdb_value;
        end
      end
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_nxt[i] = snooped[i];
    end
    if (load) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        if (i >= sel) ent_nxt[i] = snooped[i + 1];
      end
      ent_nxt[DEPTH-1] = '0;
    end
    if (accept) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (32'(occ_after) == i) ent_nxt[i] = new_ent;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= '0;
      occ           <= '0;
      issue_valid   <= 1'b0;
      issue_op1     <= '0;
      issue_op2     <= '0;
      issue_alu_op  <= '0;
      issue_dst_tag <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= ent_nxt[i];
      occ <= occ + OCC_W'(accept) - OCC_W'(load);
      if (load) begin
        issue_valid   <= 1'b1;
        issue_op1     <= sel_ent.val1;
        issue_op2     <= sel_ent.val2;
        issue_alu_op  <= sel_ent.alu_op;
        issue_dst_tag <= sel_ent.dst_tag;
      end else if (bus.issue_ready) begin
        issue_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench: a queue-based model predicts each issued instruction and a
// negedge monitor compares whenever the ALU consumes the issue register.
module tb_alu_reservation_station;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  alu_reservation_station_if #(.DEPTH(DEPTH), .TAG_W(3), .DATA_W(16)) bus ();

  alu_reservation_station #(.DEPTH(DEPTH), .TAG_W(3), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  dst;
    bit          r1;
    logic [2:0]  t1;
    logic [15:0] v1;
    bit          r2;
    logic [2:0]  t2;
    logic [15:0] v2;
  } ins_t;

  typedef struct {
    logic [15:0] op1;
    logic [15:0] op2;
    logic [3:0]  op;
    logic [2:0]  dst;
  } exp_t;

  ins_t mq[$];
  exp_t exp_q[$];
  bit   m_iv;
  int   errors;
  int   checks;
  bit   mon_en;
  bit   hold_pend;
  exp_t held;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one clock edge of the station, written over plain queues.
  task automatic model_step();
    int   sel;
    bit   acc;
    ins_t n;
    exp_t e;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_iv = 0;
      return;
    end
    sel = -1;
    foreach (mq[i]) if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
    acc = bus.disp_valid && (mq.size() < DEPTH);
    if (sel >= 0 && (!m_iv || bus.issue_ready)) begin
      e.op1 = mq[sel].v1; e.op2 = mq[sel].v2; e.op = mq[sel].op; e.dst = mq[sel].dst;
      exp_q.push_back(e);
      mq.delete(sel);
      m_iv = 1;
    end else if (bus.issue_ready) begin
      m_iv = 0;
    end
    if (bus.cdb_valid) begin
      foreach (mq[i]) begin
        if (!mq[i].r1 && mq[i].t1 == bus.cdb_tag) begin mq[i].r1 = 1; mq[i].v1 = bus.cdb_value; end
        if (!mq[i].r2 && mq[i].t2 == bus.cdb_tag) begin mq[i].r2 = 1; mq[i].v2 = bus.cdb_value; end
      end
    end
    if (acc) begin
      n.op = bus.disp_alu_op; n.dst = bus.disp_dst_tag;
      n.r1 = bus.disp_src1_rdy; n.t1 = bus.disp_src1_tag; n.v1 = bus.disp_src1_val;
      n.r2 = bus.disp_src2_rdy; n.t2 = bus.disp_src2_tag; n.v2 = bus.disp_src2_val;
      if (!n.r1 && bus.cdb_valid && bus.cdb_tag == n.t1) begin n.r1 = 1; n.v1 = bus.cdb_value; end
      if (!n.r2 && bus.cdb_valid && bus.cdb_tag == n.t2) begin n.r2 = 1; n.v2 = bus.cdb_value; end
      mq.push_back(n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_disp(input logic [3:0] op, input logic [2:0] dst,
                          input bit r1, input logic [2:0] t1, input logic [15:0] v1,
                          input bit r2, input logic [2:0] t2, input logic [15:0] v2);
    bus.disp_valid    = 1'b1;
    bus.disp_alu_op   = op;
    bus.disp_dst_tag  = dst;
    bus.disp_src1_rdy = r1;
    bus.disp_src1_tag = t1;
    bus.disp_src1_val = v1;
    bus.disp_src2_rdy = r2;
    bus.disp_src2_tag = t2;
    bus.disp_src2_val = v2;
  endtask

  task automatic set_cdb(input logic [2:0] tag, input logic [15:0] val);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_value = val;
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0;
    bus.cdb_valid  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("occupancy", 32'(bus.occupancy), mq.size());
      chk("disp_ready", 32'(bus.disp_ready), 32'(mq.size() < DEPTH));
      chk("issue_valid", 32'(bus.issue_valid), 32'(m_iv));
      if (hold_pend) begin
        chk("hold_op1", 32'(bus.issue_op1), 32'(held.op1));
        chk("hold_op2", 32'(bus.issue_op2), 32'(held.op2));
        chk("hold_alu_op", 32'(bus.issue_alu_op), 32'(held.op));
        chk("hold_dst", 32'(bus.issue_dst_tag), 32'(held.dst));
      end
      hold_pend = bus.issue_valid && !bus.issue_ready && !rst;
      held.op1 = bus.issue_op1; held.op2 = bus.issue_op2;
      held.op = bus.issue_alu_op; held.dst = bus.issue_dst_tag;
      if (bus.issue_valid && bus.issue_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_issue: got dst=%0d op1=0x%0h, no issue expected",
                   bus.issue_dst_tag, bus.issue_op1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_op1", 32'(bus.issue_op1), 32'(e.op1));
          chk("sb_op2", 32'(bus.issue_op2), 32'(e.op2));
          chk("sb_alu_op", 32'(bus.issue_alu_op), 32'(e.op));
          chk("sb_dst", 32'(bus.issue_dst_tag), 32'(e.dst));
        end
      end
    end
  end

  initial begin
    errors = 0; checks = 0; mon_en = 0; hold_pend = 0; m_iv = 0;
    bus.disp_alu_op = '0; bus.disp_dst_tag = '0;
    bus.disp_src1_rdy = 1'b0; bus.disp_src1_tag = '0; bus.disp_src1_val = '0;
    bus.disp_src2_rdy = 1'b0; bus.disp_src2_tag = '0; bus.disp_src2_val = '0;
    bus.cdb_tag = '0; bus.cdb_value = '0;
    bus.issue_ready = 1'b0;
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    mon_en = 1;
    chk("rst_occ", 32'(bus.occupancy), 0);
    chk("rst_iv", 32'(bus.issue_valid), 0);
    chk("rst_ready", 32'(bus.disp_ready), 1);
    chk("rst_op1", 32'(bus.issue_op1), 0);
    chk("rst_op2", 32'(bus.issue_op2), 0);
    chk("rst_alu_op", 32'(bus.issue_alu_op), 0);
    chk("rst_dst", 32'(bus.issue_dst_tag), 0);

    // both sources ready
    bus.issue_ready = 1'b1;
    set_disp(4'd0, 3'd2, 1, 3'd0, 16'd5, 1, 3'd0, 16'd7);
    tick(); idle();
    chk("add_occ1", 32'(bus.occupancy), 1);
    chk("add_iv_early", 32'(bus.issue_valid), 0);
    tick();
    chk("add_iv", 32'(bus.issue_valid), 1);
    chk("add_op1", 32'(bus.issue_op1), 5);
    chk("add_op2", 32'(bus.issue_op2), 7);
    chk("add_alu_op", 32'(bus.issue_alu_op), 0);
    chk("add_dst", 32'(bus.issue_dst_tag), 2);
    chk("add_occ0", 32'(bus.occupancy), 0);
    tick();

    // pending operand woken by the CDB
    set_disp(4'd1, 3'd4, 0, 3'd3, 16'h0, 1, 3'd0, 16'd1);
    tick(); idle();
    repeat (4) tick();
    chk("sub_wait_iv", 32'(bus.issue_valid), 0);
    chk("sub_wait_occ", 32'(bus.occupancy), 1);
    set_cdb(3'd3, 16'h0010);
    tick(); idle();
    chk("sub_capture_iv", 32'(bus.issue_valid), 0);
    tick();
    chk("sub_iv", 32'(bus.issue_valid), 1);
    chk("sub_op1", 32'(bus.issue_op1), 16'h0010);
    chk("sub_op2", 32'(bus.issue_op2), 1);
    tick();

    // dispatch-cycle bypass
    set_disp(4'd2, 3'd5, 1, 3'd0, 16'd9, 0, 3'd5, 16'h0);
    set_cdb(3'd5, 16'hBEEF);
    tick(); idle();
    tick();
    chk("byp_iv", 32'(bus.issue_valid), 1);
    chk("byp_op1", 32'(bus.issue_op1), 9);
    chk("byp_op2", 32'(bus.issue_op2), 16'hBEEF);
    tick();

    // age order with back-pressure: B, C, A
    bus.issue_ready = 1'b0;
    set_disp(4'd3, 3'd1, 0, 3'd6, 16'h0, 1, 3'd0, 16'd2);
    tick();
    set_disp(4'd4, 3'd2, 1, 3'd0, 16'd11, 1, 3'd0, 16'd12);
    tick();
    set_disp(4'd5, 3'd3, 1, 3'd0, 16'd13, 1, 3'd0, 16'd14);
    tick(); idle();
    chk("age_b_dst", 32'(bus.issue_dst_tag), 2);
    chk("age_b_op1", 32'(bus.issue_op1), 11);
    repeat (3) tick();
    chk("age_b_held_dst", 32'(bus.issue_dst_tag), 2);
    chk("age_b_held_op2", 32'(bus.issue_op2), 12);
    chk("age_occ2", 32'(bus.occupancy), 2);
    bus.issue_ready = 1'b1;
    tick();
    chk("age_c_dst", 32'(bus.issue_dst_tag), 3);
    set_cdb(3'd6, 16'h0066);
    tick(); idle();
    chk("age_gap_iv", 32'(bus.issue_valid), 0);
    tick();
    chk("age_a_dst", 32'(bus.issue_dst_tag), 1);
    chk("age_a_op1", 32'(bus.issue_op1), 16'h0066);
    chk("age_a_alu_op", 32'(bus.issue_alu_op), 3);
    tick();

    // full station
    bus.issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_disp(4'(k + 6), 3'(k), 0, 3'd7, 16'h0, 1, 3'd0, 16'(k));
      tick();
    end
    set_disp(4'd10, 3'd5, 0, 3'd7, 16'h0, 1, 3'd0, 16'd99);
    chk("full_ready", 32'(bus.disp_ready), 0);
    chk("full_occ", 32'(bus.occupancy), 4);
    tick(); idle();
    chk("full_reject_occ", 32'(bus.occupancy), 4);
    set_cdb(3'd7, 16'h0077);
    tick(); idle();
    set_disp(4'd9, 3'd5, 0, 3'd2, 16'h0, 1, 3'd0, 16'd3);
    tick();
    chk("full_load_occ", 32'(bus.occupancy), 3);
    bus.issue_ready = 1'b1;
    tick(); idle();
    chk("full_swap_occ", 32'(bus.occupancy), 3);
    set_cdb(3'd2, 16'h0022);
    tick(); idle();
    repeat (6) tick();

    // reset mid-operation
    bus.issue_ready = 1'b0;
    set_disp(4'd11, 3'd6, 1, 3'd0, 16'd1, 1, 3'd0, 16'd2);
    tick();
    for (int k = 0; k < 3; k++) begin
      set_disp(4'd12, 3'(k), 0, 3'd4, 16'h0, 1, 3'd0, 16'd5);
      tick();
    end
    idle();
    chk("mid_occ3", 32'(bus.occupancy), 3);
    chk("mid_iv1", 32'(bus.issue_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_occ", 32'(bus.occupancy), 0);
    chk("mid_rst_iv", 32'(bus.issue_valid), 0);
    chk("mid_rst_ready", 32'(bus.disp_ready), 1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      bus.issue_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1)
        set_disp(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 16'($urandom),
                 $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 16'($urandom));
      else
        bus.disp_valid = 1'b0;
      if ($urandom_range(0, 9) < 4) set_cdb(3'($urandom_range(0, 7)), 16'($urandom));
      else bus.cdb_valid = 1'b0;
      tick();
    end

    rst = 1'b0;
    bus.disp_valid = 1'b0;
    bus.issue_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      set_cdb(3'(c % 8), 16'($urandom));
      tick();
    end
    idle();
    repeat (3) tick();
    chk("drain_occ", 32'(bus.occupancy), 0);
    chk("drain_iv", 32'(bus.issue_valid), 0);
    chk("drain_sb", exp_q.size(), 0);

    @(negedge clk);
    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
